spine_trap_ctrl: RTL and testbench

Trap controller for the spine obstacle: watches Mario's position, fires the one-cycle `trigger` pulse that launches the spine mover, then tracks the returned `spine_x` each frame and decides whether Mario was hit or escaped. Sits between the Mario motion logic and the spine mover. Its `mario_dead` output feeds the game-over/restart logic.

---
 rtl/spine_trap_ctrl.sv | 81 ++++++++
 tb/tb_spine_trap_ctrl.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/spine_trap_ctrl.sv
// spine_trap_ctrl: arms on Mario's x, fires the spine launch pulse, then judges hit or escape once per frame.
module spine_trap_ctrl #(
    parameter int TRIG_X     = 200,
    parameter int END_X      = 460,
    parameter int SPINE_Y    = 440,
    parameter int SPINE_W    = 20,
    parameter int SPINE_H    = 20,
    parameter int MARIO_W    = 20,
    parameter int MARIO_H    = 20,
    parameter int HIT_FRAMES = 2
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       frame_clk,
    input  logic       restart,
    input  logic [9:0] mario_x,
    input  logic [9:0] mario_y,
    input  logic [9:0] spine_x,
    output logic       trigger,
    output logic       mario_dead,
    output logic       trap_active
);
    typedef enum logic [2:0] {ARMED, FIRE, TRACK, DEAD, PASSED} state_t;
    state_t     state_q, state_d;
    logic [3:0] hit_cnt_q, hit_cnt_d;
    logic       frame_q, frame_d;
    logic       frame_rise, overlap, hit_last;
    logic [10:0] mx, my, sx;
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q   <= ARMED;
            hit_cnt_q <= 4'd0;
            frame_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            hit_cnt_q <= hit_cnt_d;
            frame_q   <= frame_d;
        end
    end
    // Sums are widened to 11 bits so edges near 1023 never wrap.
    always_comb begin
        mx         = {1'b0, mario_x};
        my         = {1'b0, mario_y};
        sx         = {1'b0, spine_x};
        frame_d    = frame_clk;
        frame_rise = frame_clk & ~frame_q;
        overlap    = (sx != 11'd0) && (mx < sx + 11'(SPINE_W)) && (sx < mx + 11'(MARIO_W)) &&
                     (my < 11'(SPINE_Y + SPINE_H)) && (11'(SPINE_Y) < my + 11'(MARIO_H));
        hit_last   = ({1'b0, hit_cnt_q} + 5'd1) == 5'(HIT_FRAMES);
    end
    always_comb begin
        state_d   = state_q;
        hit_cnt_d = hit_cnt_q;
        if (restart) begin
            state_d   = ARMED;
            hit_cnt_d = 4'd0;
        end else begin
            case (state_q)
                ARMED: if (frame_rise && mx >= 11'(TRIG_X)) begin
                    state_d   = FIRE;
                    hit_cnt_d = 4'd0;
                end
                FIRE: state_d = TRACK;
                TRACK: if (frame_rise) begin
                    if (overlap && hit_last) state_d = DEAD;
                    else if (overlap) hit_cnt_d = hit_cnt_q + 4'd1;
                    else begin
                        hit_cnt_d = 4'd0;
                        state_d   = (sx >= 11'(END_X)) ? PASSED : TRACK;
                    end
                end
                default: state_d = state_q;
            endcase
        end
    end
    always_comb begin
        trigger     = state_q == FIRE;
        trap_active = state_q == TRACK;
        mario_dead  = state_q == DEAD;
    end
endmodule

// File: tb/tb_spine_trap_ctrl.sv
// tb_spine_trap_ctrl: directed scenarios plus random traffic, checked each cycle against a behavioural model.
module tb_spine_trap_ctrl;
    logic       Clk = 0, Reset = 0, frame_clk = 0, restart = 0;
    logic [9:0] mario_x = 0, mario_y = 0, spine_x = 0;
    logic       trigger, mario_dead, trap_active;
    int n_cmp = 0, n_bad = 0;
    bit m_prev, m_armed, m_trig, m_track, m_dead, m_passed;
    int m_hits;

    spine_trap_ctrl dut (
        .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk), .restart(restart),
        .mario_x(mario_x), .mario_y(mario_y), .spine_x(spine_x),
        .trigger(trigger), .mario_dead(mario_dead), .trap_active(trap_active)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string name, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
        end
    endtask

    function automatic bit hits(input int mx, input int my, input int sx);
        return sx != 0 && mx < sx + 20 && sx < mx + 20 && my < 440 + 20 && 440 < my + 20;
    endfunction

    // Behavioural model: booleans for the game phase, an integer run of overlapping frames.
    initial begin
        forever begin
            @(posedge Clk or posedge Reset);
            if (Reset) begin
                m_prev = 0; m_armed = 1; m_trig = 0; m_track = 0; m_dead = 0; m_passed = 0; m_hits = 0;
            end else begin
                bit rise;
                rise = frame_clk && !m_prev;
                m_prev = frame_clk;
                if (restart) begin
                    m_armed = 1; m_trig = 0; m_track = 0; m_dead = 0; m_passed = 0; m_hits = 0;
                end else if (m_trig) begin
                    m_trig = 0; m_track = 1;
                end else if (m_armed && rise && int'(mario_x) >= 200) begin
                    m_armed = 0; m_trig = 1; m_hits = 0;
                end else if (m_track && rise) begin
                    if (hits(int'(mario_x), int'(mario_y), int'(spine_x))) begin
                        m_hits++;
                        if (m_hits >= 2) begin m_track = 0; m_dead = 1; end
                    end else begin
                        m_hits = 0;
                        if (int'(spine_x) >= 460) begin m_track = 0; m_passed = 1; end
                    end
                end
            end
        end
    end

    always @(negedge Clk) begin
        if (!Reset) begin
            chk("model_trigger", trigger, m_trig);
            chk("model_trap_active", trap_active, m_track);
            chk("model_mario_dead", mario_dead, m_dead);
        end
    end

    task automatic frame();
        @(negedge Clk) frame_clk = 1;
        @(negedge Clk) frame_clk = 0;
    endtask

    task automatic do_restart();
        @(negedge Clk) restart = 1;
        @(negedge Clk) restart = 0;
    endtask

    task automatic launch(input logic [9:0] mx);
        mario_x = mx;
        frame();
        chk("launch_trigger", trigger, 1'b1);
        @(negedge Clk);
        chk("launch_track", trap_active, 1'b1);
    endtask

    initial begin
        int trig_seen;
        mario_y = 10'd430;
        @(negedge Clk) Reset = 1;
        @(negedge Clk);
        chk("reset_trigger", trigger, 1'b0);
        chk("reset_active", trap_active, 1'b0);
        chk("reset_dead", mario_dead, 1'b0);
        Reset = 0;
        mario_x = 10'd199;
        repeat (3) begin
            frame();
            chk("below_trig_x", trigger, 1'b0);
        end
        mario_x = 10'd200;
        frame();
        chk("trig_pulse", trigger, 1'b1);
        @(negedge Clk);
        chk("trig_single", trigger, 1'b0);
        chk("track_after_fire", trap_active, 1'b1);
        mario_x = 10'd300; spine_x = 10'd290;
        frame();
        chk("one_hit_alive", mario_dead, 1'b0);
        frame();
        chk("two_hits_dead", mario_dead, 1'b1);
        repeat (5) begin
            frame();
            chk("dead_sticky", mario_dead, 1'b1);
        end
        do_restart();
        chk("restart_clears_dead", mario_dead, 1'b0);
        launch(10'd300);
        spine_x = 10'd290; frame();
        spine_x = 10'd0;   frame();
        spine_x = 10'd290; frame();
        chk("broken_run_alive", mario_dead, 1'b0);
        chk("broken_run_track", trap_active, 1'b1);
        spine_x = 10'd460; frame();
        chk("passed_inactive", trap_active, 1'b0);
        chk("passed_alive", mario_dead, 1'b0);
        do_restart();
        spine_x = 10'd0;
        launch(10'd450);
        spine_x = 10'd445; frame();
        spine_x = 10'd460; frame();
        chk("end_x_dead_wins", mario_dead, 1'b1);
        do_restart();
        mario_x = 10'd300;
        @(negedge Clk) begin frame_clk = 1; restart = 1; end
        @(negedge Clk) begin frame_clk = 0; restart = 0; end
        chk("restart_beats_fire", trigger, 1'b0);
        @(negedge Clk);
        chk("restart_no_late_fire", trigger, 1'b0);
        frame();
        chk("fire_mid_reset_pre", trigger, 1'b1);
        #2 Reset = 1;
        #1 chk("async_reset_fire", trigger, 1'b0);
        @(negedge Clk) Reset = 0;
        launch(10'd300);
        #2 Reset = 1;
        #1 chk("async_reset_track", trap_active, 1'b0);
        @(negedge Clk) Reset = 0;
        spine_x = 10'd500; trig_seen = 0;
        @(negedge Clk) frame_clk = 1;
        repeat (10) begin
            @(negedge Clk);
            trig_seen += int'(trigger);
        end
        frame_clk = 0;
        chk("held_frame_one_trigger", trig_seen == 1, 1'b1);
        chk("held_frame_no_reeval", trap_active, 1'b1);
        do_restart();
        repeat (3000) begin
            @(negedge Clk);
            Reset = ($urandom_range(0, 299) == 0);
            restart = ($urandom_range(0, 59) == 0);
            if ($urandom_range(0, 2) == 0) frame_clk = ~frame_clk;
            mario_x = 10'($urandom_range(180, 480));
            mario_y = 10'($urandom_range(410, 470));
            case ($urandom_range(0, 3))
                0: spine_x = 10'd0;
                1: spine_x = 10'($urandom_range(455, 470));
                default: spine_x = 10'(int'(mario_x) + int'($urandom_range(0, 50)) - 25);
            endcase
        end
        Reset = 0; restart = 0;
        repeat (2) @(negedge Clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
